// File: rtl/fetch_pkg.sv
// Shared types and default constants for the parameterised fetch stage.
package fetch_pkg;

   localparam int          DEF_XLEN     = 32;
   localparam int          DEF_PC_STEP  = 4;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   // Fetch FSM states; FAULT is terminal until reset.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_clk_en.sv
// Fetch-rate divider: a free-running 0..FETCH_DIV-1 counter that raises
// tick_o for one cycle per period. No derived clock is produced.
module fetch_clk_en #(
   parameter int FETCH_DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic tick_o
);

   localparam int            CW   = (FETCH_DIV > 1) ? $clog2(FETCH_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(FETCH_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: wrap to zero after the terminal value.
   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
   end

   // Counter register; with FETCH_DIV=1 it stays at zero and tick is constant.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/fetch_unit_param.sv
// Instruction-fetch stage: PC sequencing, redirect, imem req/ack handshake
// with timeout, and a valid/ready output toward decode.
//
// Handshakes: imem_req rises with imem_addr and both stay stable until
// imem_ack is seen at a clock edge (a request is never withdrawn, except by a
// timeout into FAULT). Toward decode, ir_out/npc_out are stable while
// ir_valid=1; the instruction is consumed on a clock edge where
// ir_valid && ir_ready, unless a redirect squashes it in the same cycle.
module fetch_unit_param
   import fetch_pkg::*;
#(
   parameter int               XLEN      = DEF_XLEN,
   parameter int               PC_STEP   = DEF_PC_STEP,
   parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(DEF_RESET_PC),
   parameter int               FETCH_DIV = 4,
   parameter int               MAX_WAIT  = 15
) (
   input  logic            clock1,
   input  logic            reset1,
   input  logic            branch_en,
   input  logic            jump_en,
   input  logic [XLEN-1:0] target_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] ir_out,
   output logic [XLEN-1:0] npc_out,
   output logic            ir_valid,
   input  logic            ir_ready,
   output logic            fetch_fault
);

   localparam int            WW        = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] addr_q;
   logic            req_q;
   logic [XLEN-1:0] ir_q;
   logic [XLEN-1:0] npc_q;
   logic            valid_q;
   logic            fault_q;
   logic [WW-1:0]   wait_q;
   logic            drop_q;

   logic            tick;
   logic            redirect;
   logic [XLEN-1:0] pc_inc;

   fetch_clk_en #(
      .FETCH_DIV (FETCH_DIV)
   ) u_clk_en (
      .clk_i  (clock1),
      .rst_i  (reset1),
      .tick_o (tick)
   );

   // jump_en outranks branch_en, but both carry target_pc, so the merged
   // request is all the datapath needs.
   assign redirect = jump_en | branch_en;
   assign pc_inc   = pc_q + XLEN'(PC_STEP);

   // Fetch FSM and datapath registers; all outputs are registered here.
   always_ff @(posedge clock1 or posedge reset1) begin
      if (reset1) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         addr_q  <= RESET_PC;
         req_q   <= 1'b0;
         ir_q    <= '0;
         npc_q   <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         wait_q  <= '0;
         drop_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (redirect) pc_q <= target_pc;
               if (tick) begin
                  state_q <= ST_REQ;
                  req_q   <= 1'b1;
                  addr_q  <= redirect ? target_pc : pc_q;
                  wait_q  <= '0;
               end
            end
            ST_REQ: begin
               if (redirect) pc_q <= target_pc;
               if (imem_ack) begin
                  req_q  <= 1'b0;
                  wait_q <= '0;
                  if (drop_q || redirect) begin
                     // Response belongs to a stale path; pc already redirected.
                     drop_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     ir_q    <= imem_rdata;
                     npc_q   <= pc_inc;
                     pc_q    <= pc_inc;
                     valid_q <= 1'b1;
                     state_q <= ST_HOLD;
                  end
               end else if (wait_q == WAIT_LAST) begin
                  req_q   <= 1'b0;
                  fault_q <= 1'b1;
                  state_q <= ST_FAULT;
               end else begin
                  wait_q <= wait_q + WW'(1);
                  if (redirect) drop_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  // Squash wins over a coincident decode handshake.
                  pc_q    <= target_pc;
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (ir_ready) begin
                  valid_q <= 1'b0;
                  if (tick) begin
                     state_q <= ST_REQ;
                     req_q   <= 1'b1;
                     addr_q  <= pc_q;
                     wait_q  <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_FAULT: begin
               // Frozen until reset1.
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = addr_q;
   assign ir_out      = ir_q;
   assign npc_out     = npc_q;
   assign ir_valid    = valid_q;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit_param.sv
// Directed bench for fetch_unit_param: one instance at FETCH_DIV=4 and one at
// FETCH_DIV=1 share all inputs; per-cycle vector tables plus hand sequences.
module tb_fetch_unit_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        br = 1'b0, jp = 1'b0, rdy = 1'b1, ack = 1'b0;
   logic [31:0] tgt = '0, rdata = '0;

   logic        req4, v4, f4, req1, v1, f1;
   logic [31:0] addr4, ir4, npc4, addr1, ir1, npc1;

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      logic        br, jp;
      logic [31:0] tgt;
      logic        rdy, ack;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_v;
      logic [31:0] e_ir, e_npc;
      logic        e_f;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] exp_q[$];
   bit          mon_en = 1'b0;
   logic        v4_prev = 1'b0;

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   fetch_unit_param #(.FETCH_DIV(4), .MAX_WAIT(15)) u4 (
      .clock1(clk), .reset1(rst), .branch_en(br), .jump_en(jp), .target_pc(tgt),
      .imem_req(req4), .imem_addr(addr4), .imem_ack(ack), .imem_rdata(rdata),
      .ir_out(ir4), .npc_out(npc4), .ir_valid(v4), .ir_ready(rdy), .fetch_fault(f4));

   fetch_unit_param #(.FETCH_DIV(1), .MAX_WAIT(15)) u1 (
      .clock1(clk), .reset1(rst), .branch_en(br), .jump_en(jp), .target_pc(tgt),
      .imem_req(req1), .imem_addr(addr1), .imem_ack(ack), .imem_rdata(rdata),
      .ir_out(ir1), .npc_out(npc1), .ir_valid(v1), .ir_ready(rdy), .fetch_fault(f1));

   // scoreboard: each new delivery on the DIV=4 instance pops the expected word
   always @(posedge clk) begin
      #2;
      if (mon_en && v4 && !v4_prev) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL sb_delivery: got ir=%08h, expected no delivery", ir4);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (ir4 !== e) begin
               n_miss++;
               $display("FAIL sb_delivery: got ir=%08h, expected %08h", ir4, e);
            end
         end
      end
      v4_prev = v4;
   end

   // driver tasks
   task automatic chk(input string name, input bit s1, input logic e_req,
                      input logic [31:0] e_addr, input logic e_v,
                      input logic [31:0] e_ir, input logic [31:0] e_npc, input logic e_f);
      logic a_req, a_v, a_f;
      logic [31:0] a_addr, a_ir, a_npc;
      if (s1) begin
         a_req = req1; a_addr = addr1; a_v = v1; a_ir = ir1; a_npc = npc1; a_f = f1;
      end else begin
         a_req = req4; a_addr = addr4; a_v = v4; a_ir = ir4; a_npc = npc4; a_f = f4;
      end
      n_vec++;
      if (a_req !== e_req || a_addr !== e_addr || a_v !== e_v ||
          a_ir !== e_ir || a_npc !== e_npc || a_f !== e_f) begin
         n_miss++;
         $display("FAIL %s: got req=%0b addr=%08h valid=%0b ir=%08h npc=%08h fault=%0b, expected req=%0b addr=%08h valid=%0b ir=%08h npc=%08h fault=%0b",
                  name, a_req, a_addr, a_v, a_ir, a_npc, a_f,
                  e_req, e_addr, e_v, e_ir, e_npc, e_f);
      end
   endtask

   task automatic add(input logic i_br, input logic i_jp, input logic [31:0] i_tgt,
                      input logic i_rdy, input logic i_ack, input logic [31:0] i_rdata,
                      input logic e_req, input logic [31:0] e_addr, input logic e_v,
                      input logic [31:0] e_ir, input logic [31:0] e_npc, input logic e_f);
      vec_t v;
      v.br = i_br; v.jp = i_jp; v.tgt = i_tgt; v.rdy = i_rdy; v.ack = i_ack;
      v.rdata = i_rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v;
      v.e_ir = e_ir; v.e_npc = e_npc; v.e_f = e_f;
      tbl.push_back(v);
   endtask

   task automatic set_idle_inputs();
      br = 1'b0; jp = 1'b0; tgt = '0; rdy = 1'b1; ack = 1'b0; rdata = '0;
   endtask

   // Leaves the bench at a falling edge with reset just released.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      set_idle_inputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Row i drives inputs for the cycle ending at edge i+1, then checks.
   task automatic run_table(input bit s1, input string tag);
      for (int i = 0; i < tbl.size(); i++) begin
         br = tbl[i].br; jp = tbl[i].jp; tgt = tbl[i].tgt;
         rdy = tbl[i].rdy; ack = tbl[i].ack; rdata = tbl[i].rdata;
         @(posedge clk);
         #1;
         chk($sformatf("%s_edge%0d", tag, i + 1), s1, tbl[i].e_req, tbl[i].e_addr,
             tbl[i].e_v, tbl[i].e_ir, tbl[i].e_npc, tbl[i].e_f);
         @(negedge clk);
      end
      set_idle_inputs();
   endtask

   task automatic step_chk(input string name, input logic e_req, input logic [31:0] e_addr,
                           input logic e_v, input logic e_f);
      @(posedge clk);
      #1;
      chk(name, 1'b0, e_req, e_addr, e_v, 32'h0, 32'h0, e_f);
      @(negedge clk);
   endtask

   initial begin
      // ---------------- DIV=4 main stream ----------------
      do_reset();
      #1;
      chk("reset_div4", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      chk("reset_div1", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

      tbl.delete();
      for (int i = 0; i < 3; i++)
         add(0, 0, 0, 1, 0, 0,            0, 32'h0, 0, 32'h0, 32'h0, 0);
      add(0, 0, 0, 1, 0, 0,               1, 32'h0, 0, 32'h0, 32'h0, 0);
      add(0, 0, 0, 1, 1, 32'hA000_0001,   0, 32'h0, 1, 32'hA000_0001, 32'h4, 0);
      for (int i = 0; i < 6; i++)  // decode stall
         add(0, 0, 0, 0, 0, 0,            0, 32'h0, 1, 32'hA000_0001, 32'h4, 0);
      add(0, 0, 0, 1, 0, 0,               1, 32'h4, 0, 32'hA000_0001, 32'h4, 0);
      add(0, 0, 0, 1, 1, 32'hA000_0002,   0, 32'h4, 1, 32'hA000_0002, 32'h8, 0);
      add(0, 0, 0, 1, 0, 0,               0, 32'h4, 0, 32'hA000_0002, 32'h8, 0);
      add(0, 0, 0, 1, 0, 0,               0, 32'h4, 0, 32'hA000_0002, 32'h8, 0);
      add(0, 0, 0, 1, 0, 0,               1, 32'h8, 0, 32'hA000_0002, 32'h8, 0);
      add(0, 0, 0, 1, 0, 0,               1, 32'h8, 0, 32'hA000_0002, 32'h8, 0);
      add(0, 1, 32'h100, 1, 0, 0,         1, 32'h8, 0, 32'hA000_0002, 32'h8, 0);
      add(0, 0, 0, 1, 0, 0,               1, 32'h8, 0, 32'hA000_0002, 32'h8, 0);
      add(0, 0, 0, 1, 1, 32'hDEAD_0000,   0, 32'h8, 0, 32'hA000_0002, 32'h8, 0);
      for (int i = 0; i < 3; i++)
         add(0, 0, 0, 1, 0, 0,            0, 32'h8, 0, 32'hA000_0002, 32'h8, 0);
      add(0, 0, 0, 1, 0, 0,               1, 32'h100, 0, 32'hA000_0002, 32'h8, 0);
      add(0, 0, 0, 1, 1, 32'hB000_0100,   0, 32'h100, 1, 32'hB000_0100, 32'h104, 0);
      add(1, 1, 32'h40, 1, 0, 0,          0, 32'h100, 0, 32'hB000_0100, 32'h104, 0);
      add(0, 0, 0, 1, 0, 0,               0, 32'h100, 0, 32'hB000_0100, 32'h104, 0);
      add(0, 0, 0, 1, 0, 0,               1, 32'h40, 0, 32'hB000_0100, 32'h104, 0);
      add(0, 0, 0, 1, 1, 32'hC000_0040,   0, 32'h40, 1, 32'hC000_0040, 32'h44, 0);
      add(0, 0, 0, 1, 0, 0,               0, 32'h40, 0, 32'hC000_0040, 32'h44, 0);
      add(1, 0, 32'h200, 1, 0, 0,         0, 32'h40, 0, 32'hC000_0040, 32'h44, 0);
      add(0, 0, 0, 1, 0, 0,               1, 32'h200, 0, 32'hC000_0040, 32'h44, 0);
      add(0, 0, 0, 1, 1, 32'hD000_0200,   0, 32'h200, 1, 32'hD000_0200, 32'h204, 0);
      add(0, 0, 0, 1, 0, 0,               0, 32'h200, 0, 32'hD000_0200, 32'h204, 0);

      exp_q.delete();
      exp_q.push_back(32'hA000_0001);
      exp_q.push_back(32'hA000_0002);
      exp_q.push_back(32'hB000_0100);
      exp_q.push_back(32'hC000_0040);
      exp_q.push_back(32'hD000_0200);
      mon_en = 1'b1;
      run_table(1'b0, "div4");
      mon_en = 1'b0;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_miss++;
         $display("FAIL sb_drain: got %0d undelivered words, expected 0", exp_q.size());
      end

      // ---------------- async reset mid-request, then timeout ----------------
      do_reset();
      for (int i = 1; i <= 3; i++)
         step_chk($sformatf("flt_idle%0d", i), 1'b0, 32'h0, 1'b0, 1'b0);
      step_chk("flt_req_start", 1'b1, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      chk("async_reset_mid_req", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 3; i++)
         step_chk($sformatf("flt2_idle%0d", i), 1'b0, 32'h0, 1'b0, 1'b0);
      step_chk("flt2_req_start", 1'b1, 32'h0, 1'b0, 1'b0);
      for (int i = 1; i <= 14; i++)
         step_chk($sformatf("flt_wait%0d", i), 1'b1, 32'h0, 1'b0, 1'b0);
      step_chk("flt_wait15_fault", 1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 1; i <= 10; i++)
         step_chk($sformatf("flt_sticky%0d", i), 1'b0, 32'h0, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      chk("fault_cleared_by_reset", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // ---------------- DIV=1 wrap-around stream ----------------
      do_reset();
      tbl.delete();
      add(0, 0, 0, 1, 0, 0,                  1, 32'h0, 0, 32'h0, 32'h0, 0);
      add(0, 0, 0, 1, 1, 32'h1111_0000,      0, 32'h0, 1, 32'h1111_0000, 32'h4, 0);
      add(0, 1, 32'hFFFF_FFF8, 1, 0, 0,      0, 32'h0, 0, 32'h1111_0000, 32'h4, 0);
      add(0, 0, 0, 1, 0, 0,                  1, 32'hFFFF_FFF8, 0, 32'h1111_0000, 32'h4, 0);
      add(0, 0, 0, 1, 1, 32'h2222_0000,      0, 32'hFFFF_FFF8, 1, 32'h2222_0000, 32'hFFFF_FFFC, 0);
      add(0, 0, 0, 1, 0, 0,                  1, 32'hFFFF_FFFC, 0, 32'h2222_0000, 32'hFFFF_FFFC, 0);
      add(0, 0, 0, 1, 1, 32'h3333_0000,      0, 32'hFFFF_FFFC, 1, 32'h3333_0000, 32'h0, 0);
      add(0, 0, 0, 1, 0, 0,                  1, 32'h0, 0, 32'h3333_0000, 32'h0, 0);
      add(0, 0, 0, 1, 1, 32'h4444_0000,      0, 32'h0, 1, 32'h4444_0000, 32'h4, 0);
      add(0, 0, 0, 1, 0, 0,                  1, 32'h4, 0, 32'h4444_0000, 32'h4, 0);
      run_table(1'b1, "div1");

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/fetch_unit_param.md
Name: fetch_unit_param

Overview:
- Parameterised instruction-fetch stage, the successor to the fixed 32-bit divided-clock fetch.
- Drives PC sequencing, branch/jump redirect and an instruction-memory request/acknowledge handshake.
- Presents instruction + next-PC to decode with a valid/ready handshake.
- Fetch rate is throttled by an internal clock-enable divider; no derived clock is generated.

Parameters:
- XLEN, 32, PC / instruction / target width.
- PC_STEP, 4, sequential PC increment in bytes.
- RESET_PC, 0, PC after reset.
- FETCH_DIV, 4, fetch-enable period in clock1 cycles (1 = every cycle; must be ≥1).
- MAX_WAIT, 15, imem wait cycles tolerated before fault (must be ≥1).

Ports:
- clock1, in, 1, sole clock, rising edge.
- reset1, in, 1, asynchronous, active-high reset.
- branch_en, in, 1, taken-branch redirect request.
- jump_en, in, 1, jump redirect request; has priority over branch_en.
- target_pc, in, XLEN, redirect address.
- imem_req, out, 1, instruction memory request.
- imem_addr, out, XLEN, request address.
- imem_ack, in, 1, memory response valid, sampled while imem_req=1.
- imem_rdata, in, XLEN, instruction word, valid with imem_ack.
- ir_out, out, XLEN, fetched instruction to decode.
- npc_out, out, XLEN, address of ir_out + PC_STEP.
- ir_valid, out, 1, ir_out/npc_out valid.
- ir_ready, in, 1, decode accepts (stall when 0).
- fetch_fault, out, 1, sticky imem timeout flag.

Behaviour:
- Reset (async, any state, mid-transaction included):
  - pc=RESET_PC, imem_addr=RESET_PC.
  - imem_req=0, ir_out=0, npc_out=0, ir_valid=0, fetch_fault=0.
  - State IDLE, div counter=0, wait counter=0, drop flag=0.
- Divider: counter runs 0..FETCH_DIV-1 every cycle; tick=1 when counter==FETCH_DIV-1, then counter wraps to 0. FETCH_DIV=1 gives tick=1 always.
- FSM states: IDLE, REQ, HOLD, FAULT.
- IDLE:
  - On tick: go to REQ, imem_req=1, imem_addr=pc.
- REQ:
  - imem_req and imem_addr are held stable until ack; a request is never withdrawn.
  - Ack is sampled at the clock edge; ack in the first REQ cycle is legal (zero-wait).
  - On ack with drop=0: ir_out=imem_rdata, npc_out=pc+PC_STEP, pc=pc+PC_STEP, ir_valid=1, imem_req=0, go to HOLD.
  - On ack with drop=1: data is discarded, drop clears, imem_req=0, go to IDLE; pc already holds the redirect target.
  - Wait counter increments each REQ cycle without ack. Reaching MAX_WAIT sets fetch_fault=1, imem_req=0, go to FAULT.
- HOLD:
  - ir_out/npc_out are held stable while ir_valid=1 and ir_ready=0.
  - On ir_ready=1: ir_valid=0 next cycle. If tick is also 1, go directly to REQ (imem_addr=pc); otherwise go to IDLE.
  - Best throughput is 1 instruction per 2 cycles at FETCH_DIV=1.
- FAULT: terminal until reset1; outputs frozen, ir_valid=0.
- Redirect (jump_en | branch_en, sampled every cycle in IDLE/REQ/HOLD):
  - pc=target_pc.
  - In REQ: drop=1.
  - In HOLD: ir_valid=0 next cycle (instruction squashed), go to IDLE.
  - In IDLE: pc updates only.
  - Redirect coincident with ack in REQ: the ack is treated as dropped (no ir_valid), pc=target_pc.
  - jump_en and branch_en together: jump_en wins (same target_pc; affects priority encoding only).
  - Redirect coincident with the HOLD handshake: the squash takes effect; the handshake is ignored.
- Arithmetic: pc+PC_STEP wraps modulo 2^XLEN; no overflow flag.

Decomposition:
- Shared package fetch_pkg holds: the state enum (IDLE/REQ/HOLD/FAULT), the default XLEN/PC_STEP constants, and RESET_PC.
- One sub-module, fetch_clk_en (parameter FETCH_DIV, outputs tick), replaces the derived fetch clock.
- The FSM and datapath stay in fetch_unit_param.

Test Plan:
- Reset sequence, FETCH_DIV=4, zero-wait ack, ir_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - First ir_valid 5 cycles after reset release, npc_out=0x4.
- ir_ready held 0 for 6 cycles after the first fetch → ir_out/npc_out stable, no new imem_req, pc=0x4 until release.
- Ack delayed 3 cycles, jump_en with target_pc=0x100 in the 2nd REQ cycle:
  - Response discarded, no ir_valid.
  - Next imem_addr=0x100, then npc_out=0x104.
- branch_en and jump_en together in HOLD with target_pc=0x40 → ir_valid drops next cycle, next fetch imem_addr=0x40.
- imem_ack never asserted, MAX_WAIT=15 → fetch_fault=1 after 15 REQ cycles, imem_req=0, fault stays until reset1 pulse clears it.
- FETCH_DIV=1, PC_STEP=4, pc preset near 0xFFFFFFF8 via jump:
  - Fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x0 (wrap).
  - One fetch per 2 cycles.
